seg7_scan_controller: RTL and testbench

// Time-multiplexed scan controller for a bank of common-cathode 7-segment digits sharing one segment bus.
// - Holds a packed BCD display value.
// - Steps through the digits one slot at a time, decoding the current nibble to segment pattern ABCDEFG.
// - Drives a one-hot digit enable, with a dead-time blank at the start of every slot to prevent ghosting.
// - Double-buffers the value so a display frame never shows a mix of old and new digits.

---
 rtl/seg7_scan_controller.sv | 184 ++++++++++++++++++
 tb/tb_seg7_scan_controller.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_controller.sv
// ----------------------------------------------------------------------------
// seg7_scan_controller
//
// Time-multiplexed scan controller for a bank of common-cathode 7-segment
// digits that share one segment bus. Each digit gets a slot of PRESCALE
// clocks. The first BLANK_CYCLES clocks of a slot are dark, which prevents
// ghosting. The rest of the slot shows the decoded BCD nibble for that digit.
//
// The displayed value is double-buffered. A load goes into a pending buffer.
// The pending buffer is copied to the active buffer only on the edge that
// starts a frame, so one frame never mixes old and new digits.
//
// Optional feature: define SEG7_SCAN_LZB_EN to enable leading-zero blanking.
// Zero digits above the most significant nonzero digit are shown dark.
// Digit 0 is never blanked.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   enable       1 = scan running, 0 = display dark (buffers retained)
//   load         1-cycle strobe that captures value
//   value        packed BCD, nibble k = digit k
//   segments     [6]=A .. [0]=G, active high, registered
//   digit_en     one-hot digit enable, active high, registered
//   frame_start  1-cycle pulse on the first cycle of the digit-0 slot
// ----------------------------------------------------------------------------
module seg7_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    output logic [6:0]              segments,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [4*NUM_DIGITS-1:0] ALL_BLANK = {NUM_DIGITS{4'hF}};

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                  state_reg, state_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [4*NUM_DIGITS-1:0] active_reg, active_next;
    logic [4*NUM_DIGITS-1:0] pending_reg, pending_next;
    logic                    pending_valid_reg, pending_valid_next;
    logic [6:0]              segments_reg, segments_next;
    logic [NUM_DIGITS-1:0]   digit_en_reg, digit_en_next;
    logic                    frame_start_reg, frame_start_next;
    logic                    commit;
    logic                    blank_digit;
    logic [3:0]              nib [NUM_DIGITS];

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h7E;
            4'd1:    decode = 7'h30;
            4'd2:    decode = 7'h6D;
            4'd3:    decode = 7'h79;
            4'd4:    decode = 7'h33;
            4'd5:    decode = 7'h5B;
            4'd6:    decode = 7'h5F;
            4'd7:    decode = 7'h70;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h73;
            default: decode = 7'h00;
        endcase
    endfunction

    // Split the buffer that will be active after this edge into nibbles.
    // A load on a commit edge is therefore visible from the first cycle of
    // slot 0, even when BLANK_CYCLES is 0.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign nib[gi] = active_next[gi*4 +: 4];
        end
    endgenerate

`ifdef SEG7_SCAN_LZB_EN
    // lead_zero[k] = digit k and every digit above it are zero.
    logic [NUM_DIGITS-1:0] lead_zero;
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign lead_zero[gi] = (nib[gi] == 4'h0);
            end else begin : g_rest
                assign lead_zero[gi] = lead_zero[gi+1] && (nib[gi] == 4'h0);
            end
        end
    endgenerate
    assign blank_digit = (idx_next != '0) && lead_zero[idx_next];
`else
    assign blank_digit = 1'b0;
`endif

    always_comb begin
        state_next         = IDLE;
        idx_next           = '0;
        cnt_next           = '0;
        commit             = 1'b0;
        active_next        = active_reg;
        pending_next       = pending_reg;
        pending_valid_next = pending_valid_reg;

        if (enable) begin
            if (state_reg == IDLE) begin
                // Starting from dark always begins a fresh frame at digit 0.
                commit = 1'b1;
            end else if (cnt_reg == CNT_LAST) begin
                if (idx_reg == IDX_LAST) begin
                    commit = 1'b1;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end else begin
                cnt_next = cnt_reg + 1'b1;
                idx_next = idx_reg;
            end
            state_next = (cnt_next < CNT_BLANK) ? BLANK : SHOW;
        end

        // On a commit edge, a simultaneous load bypasses pending.
        if (commit) begin
            if (load) begin
                active_next = value;
            end else if (pending_valid_reg) begin
                active_next = pending_reg;
            end
            pending_valid_next = 1'b0;
        end else if (load) begin
            pending_next       = value;
            pending_valid_next = 1'b1;
        end

        segments_next    = 7'h00;
        digit_en_next    = '0;
        frame_start_next = commit;
        if (state_next == SHOW) begin
            digit_en_next = NUM_DIGITS'(1) << idx_next;
            if (!blank_digit) begin
                segments_next = decode(nib[idx_next]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= IDLE;
            idx_reg           <= '0;
            cnt_reg           <= '0;
            active_reg        <= ALL_BLANK;
            pending_reg       <= ALL_BLANK;
            pending_valid_reg <= 1'b0;
            segments_reg      <= 7'h00;
            digit_en_reg      <= '0;
            frame_start_reg   <= 1'b0;
        end else begin
            state_reg         <= state_next;
            idx_reg           <= idx_next;
            cnt_reg           <= cnt_next;
            active_reg        <= active_next;
            pending_reg       <= pending_next;
            pending_valid_reg <= pending_valid_next;
            segments_reg      <= segments_next;
            digit_en_reg      <= digit_en_next;
            frame_start_reg   <= frame_start_next;
        end
    end

    assign segments    = segments_reg;
    assign digit_en    = digit_en_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg7_scan_controller.sv
module tb_seg7_scan_controller;

    localparam int ND = 4;
    localparam int PS = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * PS;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [6:0]  segments;
    logic [3:0]  digit_en;
    logic        frame_start;

    int errors = 0;
    int checks = 0;

    seg7_scan_controller #(
        .NUM_DIGITS  (ND),
        .PRESCALE    (PS),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .segments   (segments),
        .digit_en   (digit_en),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val_a;
        int          at_a;
        logic [15:0] val_b;
        int          at_b;
        logic [27:0] exp;   // {d3,d2,d1,d0} segments without leading-zero blanking
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Applies leading-zero blanking to hand-computed digit segments when the
    // option is compiled in.
    function automatic logic [27:0] adj(input logic [15:0] v, input logic [27:0] e);
        logic [27:0] r;
        r = e;
`ifdef SEG7_SCAN_LZB_EN
        for (int k = 3; k >= 1; k--) begin
            if (v[k*4 +: 4] != 4'h0) break;
            r[k*7 +: 7] = 7'h00;
        end
`endif
        return r;
    endfunction

    // Called at the negedge of the first cycle of a frame. Checks all FRAME
    // cycles and optionally pulses load at cycle at_a and/or at_b. Returns at
    // the first cycle of the following frame.
    task automatic check_frame(input string tag, input logic [27:0] exp,
                               input int at_a, input logic [15:0] va,
                               input int at_b, input logic [15:0] vb);
        int e0;
        e0 = errors;
        for (int c = 0; c < FRAME; c++) begin
            int slot, off;
            logic [3:0] exp_en;
            logic [6:0] exp_seg;
            slot = c / PS;
            off  = c % PS;
            exp_en  = (off < BC) ? 4'b0000 : (4'b0001 << slot);
            exp_seg = (off < BC) ? 7'h00 : exp[slot*7 +: 7];
            chk($sformatf("%s c%0d digit_en", tag, c), 32'(digit_en), 32'(exp_en));
            chk($sformatf("%s c%0d segments", tag, c), 32'(segments), 32'(exp_seg));
            chk($sformatf("%s c%0d frame_start", tag, c), 32'(frame_start), 32'(c == 0));
            load = 1'b0;
            if (c == at_a) begin
                load = 1'b1; value = va;
            end else if (c == at_b) begin
                load = 1'b1; value = vb;
            end
            @(negedge clk);
        end
        load = 1'b0;
        $display("frame %s: expected segs %07h, errors in frame %0d", tag, exp, errors - e0);
    endtask

    initial begin
        logic [27:0] cur;
        logic [27:0] blank0;
        logic [27:0] val4321;

        blank0  = 28'h0;
        val4321 = {7'h33, 7'h79, 7'h6D, 7'h30};

        vecs[0] = '{16'h1234, 13, 16'h0000, -1, {7'h30, 7'h6D, 7'h79, 7'h33}};
        vecs[1] = '{16'h0007, 31, 16'h0000, -1, {7'h7E, 7'h7E, 7'h7E, 7'h70}};
        vecs[2] = '{16'h5678,  3, 16'h9080, 25, {7'h73, 7'h7E, 7'h7F, 7'h7E}};
        vecs[3] = '{16'hABCF, 31, 16'h0000, -1, {7'h00, 7'h00, 7'h00, 7'h00}};
        vecs[4] = '{16'h0050, 10, 16'h0000, -1, {7'h7E, 7'h7E, 7'h5B, 7'h7E}};
        vecs[5] = '{16'h0000, 31, 16'h0000, -1, {7'h7E, 7'h7E, 7'h7E, 7'h7E}};
        vecs[6] = '{16'h0890,  5, 16'h0000, -1, {7'h7E, 7'h7F, 7'h73, 7'h7E}};

        reset = 1'b1; enable = 1'b0; load = 1'b0; value = 16'h0;
        @(negedge clk);
        @(negedge clk);
        chk("reset segments", 32'(segments), 32'h0);
        chk("reset digit_en", 32'(digit_en), 32'h0);
        chk("reset frame_start", 32'(frame_start), 32'h0);
        $display("reset: segments=%0h digit_en=%0h frame_start=%0b", segments, digit_en, frame_start);

        // Leaving reset with enable high starts a frame of blank digits.
        reset = 1'b0; enable = 1'b1;
        @(negedge clk);
        check_frame("blank1", blank0, -1, 16'h0, -1, 16'h0);
        check_frame("blank2", blank0, -1, 16'h0, -1, 16'h0);

        // Table: each load must leave the current frame alone and show up in
        // the next one.
        cur = blank0;
        for (int i = 0; i < 7; i++) begin
            logic [15:0] fin;
            fin = (vecs[i].at_b >= 0) ? vecs[i].val_b : vecs[i].val_a;
            check_frame($sformatf("vec%0d", i), cur, vecs[i].at_a, vecs[i].val_a,
                        vecs[i].at_b, vecs[i].val_b);
            cur = adj(fin, vecs[i].exp);
        end
        check_frame("vec_last", cur, -1, 16'h0, -1, 16'h0);

        // Disable during the digit-2 SHOW phase; load while dark; re-enable.
        repeat (2*PS + 4) @(negedge clk);
        chk("pre-drop digit_en", 32'(digit_en), 32'h4);
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("dark%0d digit_en", k), 32'(digit_en), 32'h0);
            chk($sformatf("dark%0d segments", k), 32'(segments), 32'h0);
            chk($sformatf("dark%0d frame_start", k), 32'(frame_start), 32'h0);
            load  = (k == 2);
            value = 16'h4321;
        end
        load = 1'b0;
        $display("disabled: held dark for 5 cycles, loaded 4321");
        enable = 1'b1;
        @(negedge clk);
        check_frame("reen1", adj(16'h4321, val4321), -1, 16'h0, -1, 16'h0);

        // Disable again with no load: the committed value must be shown on return.
        repeat (5) @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("dark2 digit_en", 32'(digit_en), 32'h0);
        enable = 1'b1;
        @(negedge clk);
        check_frame("reen2", adj(16'h4321, val4321), -1, 16'h0, -1, 16'h0);

        // Reset mid-frame with enable held high: buffers return to blank.
        repeat (12) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset digit_en", 32'(digit_en), 32'h0);
        chk("midreset segments", 32'(segments), 32'h0);
        chk("midreset frame_start", 32'(frame_start), 32'h0);
        $display("mid-frame reset: digit_en=%0h segments=%0h", digit_en, segments);
        reset = 1'b0;
        @(negedge clk);
        check_frame("postreset", blank0, -1, 16'h0, -1, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
